// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and the default geometry of the integer register file.
package rf_dump_pkg;

    localparam int DUMP_NUM_REGS = 32;
    localparam int DUMP_ADDR_W   = 5;
    localparam int DUMP_DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FETCH   = 2'b01,
        PRESENT = 2'b10,
        DONE    = 2'b11
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file through its spare read port and streams each
// register out over valid/ready, keeping a wrapping 32-bit checksum.
module regfile_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int NUM_REGS = DUMP_NUM_REGS,
    parameter int ADDR_W   = DUMP_ADDR_W,
    parameter int DATA_W   = DUMP_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Next-state and datapath updates; abort outranks handshake and start.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        checksum_d  = checksum_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (start && !abort) begin
                    index_d    = '0;
                    checksum_d = '0;
                    state_d    = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_data_d  = rf_rdata;
                    out_addr_d  = index_q;
                    out_last_d  = (index_q == LAST_IDX);
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (out_valid_q && out_ready) begin
                    checksum_d  = checksum_q + out_data_q;
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    state_d = PRESENT;
                end
            end
            DONE: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Status outputs are registered from the upcoming state so they line
        // up with it; rf_addr is presented during the FETCH cycle only.
        if (state_d == FETCH) begin
            rf_addr_d = index_d;
        end else begin
            rf_addr_d = '0;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            index_q     <= '0;
            rf_addr_q   <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            rf_addr_q   <= rf_addr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
        end
    end

    assign rf_addr   = rf_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed self-checking bench for regfile_dump_reader with a behavioural
// register file driving the combinational read port.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic [31:0] rf [32];
    assign rf_rdata = rf[rf_addr];

    int checks = 0;
    int errors = 0;

    logic [4:0]  b_addr [$];
    logic [31:0] b_data [$];
    logic        b_last [$];
    int          done_cnt = 0;

    regfile_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .rf_addr   (rf_addr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every beat accepted by the consumer (abort cancels the handshake).
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            b_addr.push_back(out_addr);
            b_data.push_back(out_data);
            b_last.push_back(out_last);
        end
        if (rst_n && done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_beat(input int k);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 300) begin
            if (out_valid && out_addr == 5'(k)) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check($sformatf("beat%0d_seen", k), 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input string tn);
        int n = 0;
        bit seen = 1'b0;
        bit prev_last_hs = 1'b0;
        while (!seen && n < 300) begin
            if (done) seen = 1'b1;
            else begin
                prev_last_hs = out_valid && out_last && out_ready;
                @(negedge clk);
                n++;
            end
        end
        check({tn, "_done_seen"}, 32'(seen), 32'd1);
        check({tn, "_done_after_last"}, 32'(prev_last_hs), 32'd1);
        check({tn, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tn, "_valid_in_done"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tn, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tn, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic verify_full(input int base, input string tn);
        check({tn, "_beat_count"}, 32'(b_addr.size() - base), 32'd32);
        if (b_addr.size() - base >= 32) begin
            for (int i = 0; i < 32; i++) begin
                check($sformatf("%s_addr%0d", tn, i), 32'(b_addr[base+i]), 32'(i));
                check($sformatf("%s_data%0d", tn, i), b_data[base+i], rf[i]);
                check($sformatf("%s_last%0d", tn, i), 32'(b_last[base+i]), 32'(i == 31));
            end
        end
    endtask

    initial begin
        int base;
        int d0;

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'h1111_1111;
        rf[2] = 32'h2222_2222;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_checksum", checksum, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_busy", 32'(busy), 32'd0);

        // Full dump with ready held high
        base = b_addr.size();
        d0   = done_cnt;
        pulse_start();
        wait_done("full");
        verify_full(base, "full");
        check("full_checksum", checksum, 32'h3333_3333);
        check("full_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Latency and backpressure
        rf[3]     = 32'h0000_C0DE;
        out_ready = 1'b0;
        base      = b_addr.size();
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat_n_busy", 32'(busy), 32'd1);
        check("lat_n_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_n1_valid", 32'(out_valid), 32'd1);
        check("lat_n1_addr", 32'(out_addr), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_beat(3);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_addr_c%0d", c), 32'(out_addr), 32'd3);
            check($sformatf("bp_data_c%0d", c), out_data, 32'h0000_C0DE);
        end
        out_ready = 1'b1;
        wait_done("bp");
        verify_full(base, "bp");
        check("bp_checksum", checksum, 32'h3333_F411);

        // Abort together with the handshake of beat 10
        for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * 32'(i);
        base = b_addr.size();
        d0   = done_cnt;
        pulse_start();
        wait_beat(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_checksum", checksum, 32'h2D2D_2D2D);
        check("abort_beats", 32'(b_addr.size() - base), 32'd10);
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // start while busy is ignored
        base = b_addr.size();
        d0   = done_cnt;
        pulse_start();
        wait_beat(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("sbusy");
        verify_full(base, "sbusy");
        check("sbusy_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("sbusy_checksum", checksum, 32'hF1F1_F1F0);
        repeat (3) @(negedge clk);
        check("sbusy_not_queued", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a dump
        pulse_start();
        wait_beat(7);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_rf_addr", 32'(rf_addr), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_data", out_data, 32'd0);
        check("mrst_addr", 32'(out_addr), 32'd0);
        check("mrst_last", 32'(out_last), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_checksum", checksum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = b_addr.size();
        pulse_start();
        wait_done("mrst");
        verify_full(base, "mrst");

        // Live write to x20 while beat 12 is presented
        rf[20] = 32'h0;
        base   = b_addr.size();
        pulse_start();
        wait_beat(12);
        rf[20] = 32'hDEAD_BEEF;
        wait_done("live");
        verify_full(base, "live");
        if (b_data.size() > base + 20) check("live_x20", b_data[base+20], 32'hDEAD_BEEF);
        else check("live_x20_present", 32'(b_data.size()), 32'(base + 21));
        check("live_checksum", checksum, 32'hBC8B_9CCB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
